// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine water path: flow-state encoding,
// flow direction codes and the water level sensor width.
package wm_pkg;

  localparam int LEVEL_W = 10;

  localparam logic FLOW_FILL  = 1'b1;
  localparam logic FLOW_DRAIN = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MONITOR = 2'd1,
    ST_ERROR   = 2'd2
  } flow_state_e;

endpackage

// File: rtl/water_flow_monitor.sv
// Fill/drain progress watchdog: flags a flow fault after MAX_STALLS windows without progress.
// Optional fill overflow trip is built in when WFM_OVERFLOW_DETECT_EN is defined.
module water_flow_monitor
  import wm_pkg::*;
#(
  parameter int WINDOW_TICKS   = 4,
  parameter int MIN_DELTA      = 5,
  parameter int MAX_STALLS     = 3,
  parameter int OVERFLOW_LEVEL = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               water_flow_reset,
  input  logic               water_flow_mode,
  input  logic [LEVEL_W-1:0] water_level_sensor,
  input  logic               tick,
  output logic               water_flow_error,
  output logic               monitor_active,
  output logic [3:0]         stall_count
);

  localparam logic [7:0]       WIN_LAST    = 8'(WINDOW_TICKS - 1);
  localparam logic [LEVEL_W:0] MIN_DELTA_L = (LEVEL_W + 1)'(MIN_DELTA);
  localparam logic [3:0]       MAX_STALL_L = 4'(MAX_STALLS);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

  flow_state_e        state_q, state_d;
  logic               error_q, error_d;
  logic [7:0]         win_q, win_d;
  logic [3:0]         stall_q, stall_d;
  logic [LEVEL_W-1:0] baseline_q, baseline_d;
  logic               mode_q, mode_d;

  logic [LEVEL_W:0]   level_ext;
  logic [LEVEL_W:0]   base_ext;
  logic [LEVEL_W:0]   delta;
  logic               end_cond;
  logic               window_pass;
  logic [3:0]         stall_inc;
  logic               overflow;

`ifdef WFM_OVERFLOW_DETECT_EN
  localparam logic [LEVEL_W:0] OVERFLOW_L = (LEVEL_W + 1)'(OVERFLOW_LEVEL);
  assign overflow = (mode_q == FLOW_FILL) && (level_ext > OVERFLOW_L);
`else
  assign overflow = 1'b0;
`endif

  // Progress is measured in the direction of flow; movement the wrong way counts as zero.
  always_comb begin
    level_ext = {1'b0, water_level_sensor};
    base_ext  = {1'b0, baseline_q};
    delta     = '0;
    end_cond  = 1'b0;
    if (mode_q == FLOW_FILL) begin
      delta    = (level_ext >= base_ext) ? (level_ext - base_ext) : '0;
      end_cond = (water_level_sensor == LEVEL_MAX);
    end else begin
      delta    = (base_ext >= level_ext) ? (base_ext - level_ext) : '0;
      end_cond = (water_level_sensor == '0);
    end
    window_pass = (delta >= MIN_DELTA_L) || end_cond;
    stall_inc   = (stall_q == 4'hF) ? stall_q : stall_q + 4'd1;
  end

  always_comb begin
    state_d    = state_q;
    error_d    = error_q;
    win_d      = win_q;
    stall_d    = stall_q;
    baseline_d = baseline_q;
    mode_d     = mode_q;

    if (water_flow_reset) begin
      state_d = ST_IDLE;
      error_d = 1'b0;
      win_d   = '0;
      stall_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          baseline_d = water_level_sensor;
          mode_d     = water_flow_mode;
          win_d      = '0;
          stall_d    = '0;
          state_d    = ST_MONITOR;
        end
        ST_MONITOR: begin
          if (overflow) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end else if (water_flow_mode != mode_q) begin
            // Direction changed under us: restart the progress measurement.
            mode_d     = water_flow_mode;
            baseline_d = water_level_sensor;
            win_d      = '0;
            stall_d    = '0;
          end else if (tick) begin
            if (win_q == WIN_LAST) begin
              baseline_d = water_level_sensor;
              win_d      = '0;
              if (window_pass) begin
                stall_d = '0;
              end else begin
                stall_d = stall_inc;
                if (stall_inc == MAX_STALL_L) begin
                  state_d = ST_ERROR;
                  error_d = 1'b1;
                end
              end
            end else begin
              win_d = win_q + 8'd1;
            end
          end
        end
        ST_ERROR: begin
          error_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          error_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      error_q    <= 1'b0;
      win_q      <= '0;
      stall_q    <= '0;
      baseline_q <= '0;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      error_q    <= error_d;
      win_q      <= win_d;
      stall_q    <= stall_d;
      baseline_q <= baseline_d;
      mode_q     <= mode_d;
    end
  end

  assign water_flow_error = error_q;
  assign monitor_active   = (state_q == ST_MONITOR);
  assign stall_count      = stall_q;

endmodule

// File: tb/tb_water_flow_monitor.sv
// Self-checking bench for water_flow_monitor: directed scenarios plus randomized
// traffic, all compared every cycle against a behavioural model of the watchdog.
module tb_water_flow_monitor;

  localparam int WT  = 4;
  localparam int MD  = 5;
  localparam int MS  = 3;
  localparam int OVF = 1000;
`ifdef WFM_OVERFLOW_DETECT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wfr = 1'b0;
  logic       wfm = 1'b1;
  logic       tick = 1'b0;
  logic [9:0] level = 10'd0;
  logic       err;
  logic       act;
  logic [3:0] stall;

  water_flow_monitor #(
    .WINDOW_TICKS  (WT),
    .MIN_DELTA     (MD),
    .MAX_STALLS    (MS),
    .OVERFLOW_LEVEL(OVF)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .water_flow_reset  (wfr),
    .water_flow_mode   (wfm),
    .water_level_sensor(level),
    .tick              (tick),
    .water_flow_error  (err),
    .monitor_active    (act),
    .stall_count       (stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: phase 0 = waiting to start, 1 = watching progress, 2 = faulted.
  int m_phase  = 0;
  bit m_err    = 1'b0;
  int m_ticks  = 0;
  int m_stalls = 0;
  int m_base   = 0;
  bit m_mode   = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_step();
    int  lvl;
    int  progress;
    bit  done;
    lvl = int'(level);
    if (reset) begin
      m_phase = 0; m_err = 1'b0; m_ticks = 0; m_stalls = 0; m_base = 0; m_mode = 1'b0;
    end else if (wfr) begin
      m_phase = 0; m_err = 1'b0; m_ticks = 0; m_stalls = 0;
    end else if (m_phase == 0) begin
      m_base = lvl; m_mode = wfm; m_ticks = 0; m_stalls = 0; m_phase = 1;
    end else if (m_phase == 1) begin
      if (OVF_EN && m_mode && lvl > OVF) begin
        m_phase = 2; m_err = 1'b1;
      end else if (wfm != m_mode) begin
        m_mode = wfm; m_base = lvl; m_ticks = 0; m_stalls = 0;
      end else if (tick) begin
        m_ticks++;
        if (m_ticks == WT) begin
          progress = m_mode ? (lvl - m_base) : (m_base - lvl);
          done     = m_mode ? (lvl == 1023) : (lvl == 0);
          if (progress >= MD || done) begin
            m_stalls = 0;
          end else begin
            m_stalls = (m_stalls < 15) ? m_stalls + 1 : 15;
            if (m_stalls == MS) begin
              m_phase = 2; m_err = 1'b1;
            end
          end
          m_base  = lvl;
          m_ticks = 0;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("model_error", int'(err), int'(m_err));
      check("model_active", int'(act), int'(m_phase == 1));
      check("model_stall", int'(stall), m_stalls);
    end
  end

  task automatic step(input bit t, input int lvl);
    @(negedge clk);
    tick  = t;
    level = 10'(lvl);
    @(posedge clk);
    #2;
  endtask

  task automatic window(input int lvl_hold, input int lvl_close);
    for (int k = 1; k <= WT; k++) step(1'b1, (k == WT) ? lvl_close : lvl_hold);
  endtask

  initial begin
    int lvl;
    int r;
    int d;

    wfm   = 1'b1;
    level = 10'd100;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_stall", int'(stall), 0);
    check("reset_active", int'(act), 0);
    check("reset_error", int'(err), 0);

    // Steady fill, +6 per window.
    step(1'b0, 100);
    check("start_active", int'(act), 1);
    lvl = 100;
    for (int w = 0; w < 10; w++) begin
      window(lvl, lvl + 6);
      lvl += 6;
      check("fill_ok_stall", int'(stall), 0);
      check("fill_ok_error", int'(err), 0);
    end

    // Level frozen at 200: three failing windows trip the fault on tick 12.
    wfr = 1'b1; step(1'b0, 200); wfr = 1'b0;
    step(1'b0, 200);
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, 200);
      if (k == 4)  check("frozen_stall1", int'(stall), 1);
      if (k == 8)  check("frozen_stall2", int'(stall), 2);
      if (k == 11) check("frozen_no_err", int'(err), 0);
    end
    check("frozen_error", int'(err), 1);
    check("frozen_stall3", int'(stall), 3);
    step(1'b1, 200);
    step(1'b1, 250);
    check("error_held", int'(err), 1);
    check("error_inactive", int'(act), 0);

    // One-cycle clear returns to idle, then monitoring resumes.
    wfr = 1'b1; step(1'b0, 50); wfr = 1'b0;
    check("clear_error", int'(err), 0);
    check("clear_idle", int'(act), 0);
    wfm = 1'b0;
    step(1'b0, 50);
    check("clear_monitor", int'(act), 1);

    // Drain 50 -> 0, then sit at empty.
    lvl = 50;
    for (int w = 0; w < 8; w++) begin
      window(lvl, (lvl >= 10) ? lvl - 10 : 0);
      lvl = (lvl >= 10) ? lvl - 10 : 0;
      check("drain_stall", int'(stall), 0);
    end
    check("drain_error", int'(err), 0);

    // Two failing fill windows, then flip to drain at a new level.
    wfm = 1'b1;
    step(1'b0, 300);
    window(300, 300);
    window(300, 300);
    check("flip_pre_stall", int'(stall), 2);
    wfm = 1'b0;
    step(1'b0, 280);
    check("flip_stall_clr", int'(stall), 0);
    check("flip_active", int'(act), 1);
    window(276, 276);
    check("flip_new_base", int'(stall), 1);
    window(276, 276);
    check("flip_no_err", int'(err), 0);
    window(276, 276);
    check("flip_error", int'(err), 1);

    // Full drum during fill counts as progress.
    wfr = 1'b1; step(1'b0, 1023); wfr = 1'b0;
    wfm = 1'b1;
    step(1'b0, 1023);
    window(1023, 1023);
    window(1023, 1023);
`ifdef WFM_OVERFLOW_DETECT_EN
    check("full_overflow", int'(err), 1);
`else
    check("full_stall", int'(stall), 0);
    check("full_error", int'(err), 0);
`endif

    // Delta exactly MIN_DELTA passes, one less fails.
    wfr = 1'b1; step(1'b0, 500); wfr = 1'b0;
    step(1'b0, 500);
    window(500, 502);
    check("delta2_fail", int'(stall), 1);
    window(502, 507);
    check("delta5_pass", int'(stall), 0);
    window(507, 511);
    check("delta4_fail", int'(stall), 1);
    step(1'b1, 511);
    step(1'b1, 511);

    // Asynchronous reset mid-window.
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_stall", int'(stall), 0);
    check("async_active", int'(act), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Fill overflow above threshold with no tick.
    wfm = 1'b1;
    step(1'b0, 900);
    step(1'b0, 1001);
`ifdef WFM_OVERFLOW_DETECT_EN
    check("overflow_error", int'(err), 1);
`else
    check("overflow_ignored", int'(err), 0);
    check("overflow_active", int'(act), 1);
`endif

    // Randomized traffic.
    lvl = 600;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      r     = int'($urandom_range(0, 999));
      reset = (r < 3);
      wfr   = (r >= 3 && r < 15);
      if ($urandom_range(0, 99) < 3) wfm = ~wfm;
      tick = ($urandom_range(0, 2) == 0);
      r = int'($urandom_range(0, 99));
      if (r < 3) lvl = 0;
      else if (r < 6) lvl = 1023;
      else begin
        d = int'($urandom_range(0, 6)) - 2;
        lvl = wfm ? lvl + d : lvl - d;
        if (lvl < 0) lvl = 0;
        if (lvl > 1023) lvl = 1023;
      end
      level = 10'(lvl);
    end
    @(negedge clk);
    reset = 1'b0;
    wfr   = 1'b0;
    tick  = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
